// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the RISC datapath.
//
// Handshake: the sequencer raises mem_read or mem_write, with i_or_d
// selecting the address, and holds all of them steady until the memory
// answers with mem_ready. A transfer completes in the cycle where a strobe
// and mem_ready are both high. mem_ready has no meaning while no strobe is up.
//
// Signals:
//   opcode        IR[15:13] from the instruction register (datapath -> ctrl)
//   mem_ready     memory finishes the current access this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load qualified by ALU zero in the datapath
//   pc_source     00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d        memory address: 0 PC, 1 ALUOut
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   ir_write      instruction register load
//   reg_dst       destination register: 0 rt, 1 rd
//   mem_to_reg    write-back source: 0 ALUOut, 1 MDR
//   reg_write     register-file write enable
//   alu_src_a     ALU A operand: 0 PC, 1 reg A
//   alu_src_b     ALU B operand: 00 reg B, 01 constant 1, 10 sign-ext imm
//   alu_op        00 add, 01 sub, 10 funct-decoded
interface multicycle_control_if;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  // Sequencer side.
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op
  );

  // Datapath / memory side.
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RISC datapath. Steps each instruction
// through fetch, decode, execute, memory and write-back phases so a single
// ALU and a single memory port are time-shared across phases.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   bus           control bus (master side), see multicycle_control_if
//   halted        HALT executed; sticky until reset
//   illegal_op    one-cycle pulse when opcode 110 is decoded
//   instr_retired count of completed instructions, wraps to 0
//   state         current state encoding, for debug
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_if.master     bus,
  output logic                     halted,
  output logic                     illegal_op,
  output logic [CNT_W-1:0]         instr_retired,
  output logic [3:0]               state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EX     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EX     = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           stateQ, stateD;
  logic [CNT_W-1:0] retiredQ;
  logic             retire;

  logic       pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA;
  logic [1:0] pcSource, aluSrcB, aluOp;
  logic       haltedD, illegalD;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= FETCH;
      retiredQ <= '0;
    end else begin
      stateQ <= stateD;
      if (retire) retiredQ <= retiredQ + CNT_ONE;
    end
  end

  always_comb begin
    stateD      = stateQ;
    retire      = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 2'b00;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    haltedD     = 1'b0;
    illegalD    = 1'b0;

    case (stateQ)
      FETCH: begin
        // ALU computes PC+1 while memory returns the instruction.
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (bus.mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          stateD  = DECODE;
        end
      end
      DECODE: begin
        // Branch target PC+imm is precomputed into ALUOut here.
        aluSrcB = 2'b10;
        case (bus.opcode)
          3'b000:         stateD = R_EX;
          3'b001:         stateD = I_EX;
          3'b010, 3'b011: stateD = MEM_ADDR;
          3'b100:         stateD = BRANCH;
          3'b101:         stateD = JUMP;
          3'b110: begin
            illegalD = 1'b1;
            stateD   = FETCH;
          end
          default: begin
            // HALT counts as retired on entry.
            retire = 1'b1;
            stateD = HALT;
          end
        endcase
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        stateD  = (bus.opcode == 3'b011) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (bus.mem_ready) stateD = MEM_WB;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire   = 1'b1;
        stateD   = FETCH;
      end
      MEM_WR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        if (bus.mem_ready) begin
          retire = 1'b1;
          stateD = FETCH;
        end
      end
      R_EX: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        stateD  = R_WB;
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        retire   = 1'b1;
        stateD   = FETCH;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        retire      = 1'b1;
        stateD      = FETCH;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        retire   = 1'b1;
        stateD   = FETCH;
      end
      I_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        stateD  = I_WB;
      end
      I_WB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        stateD   = FETCH;
      end
      HALT: begin
        haltedD = 1'b1;
      end
      default: stateD = FETCH;
    endcase

    // Reset silences every control output immediately, whatever state the
    // register still holds, so a mid-access reset cannot write memory.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      pcSource    = 2'b00;
      iOrD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      haltedD     = 1'b0;
      illegalD    = 1'b0;
    end
  end

  assign bus.pc_write      = pcWrite;
  assign bus.pc_write_cond = pcWriteCond;
  assign bus.pc_source     = pcSource;
  assign bus.i_or_d        = iOrD;
  assign bus.mem_read      = memRead;
  assign bus.mem_write     = memWrite;
  assign bus.ir_write      = irWrite;
  assign bus.reg_dst       = regDst;
  assign bus.mem_to_reg    = memToReg;
  assign bus.reg_write     = regWrite;
  assign bus.alu_src_a     = aluSrcA;
  assign bus.alu_src_b     = aluSrcB;
  assign bus.alu_op        = aluOp;

  assign halted        = haltedD;
  assign illegal_op    = illegalD;
  assign instr_retired = retiredQ;
  assign state         = stateQ;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. The reference model follows each
// instruction as a list of phases (a route) chosen from its opcode, and
// counts an instruction as retired when it leaves its last phase.
module tb_multicycle_control_fsm;
  localparam int CW = 4;
  // Bit positions of the strobes inside the packed control word.
  localparam logic [15:0] STROBE_MASK = 16'hC720;
  localparam logic [15:0] FETCH_DONE  = 16'h8100;

  logic          clk = 1'b0;
  logic          rst;
  logic          halted, illegal_op;
  logic [CW-1:0] instr_retired;
  logic [3:0]    state;
  logic [15:0]   dutCtrl;

  multicycle_control_if bus ();

  multicycle_control_fsm #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired),
    .state         (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign dutCtrl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                    bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                    bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op};

  // scoreboard / model state
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [15:0] expTab [0:12];
  int          mState = 0, mNext = 0, mCnt = 0, mCntNext = 0;
  int          route[$];
  logic [2:0]  curOp = 3'd0;

  function automatic logic [15:0] ctrl(input bit pw, input bit pwc,
      input int ps, input bit iod, input bit mr, input bit mw, input bit irw,
      input bit rd, input bit m2r, input bit rw, input bit asa, input int asb,
      input int aop);
    return {pw, pwc, 2'(ps), iod, mr, mw, irw, rd, m2r, rw, asa, 2'(asb),
            2'(aop)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare DUT against model, then advance the model for the coming edge.
  task automatic check_cycle();
    logic [15:0] e;
    int nx;
    if (rst) begin
      chk("rst_strobes", int'(dutCtrl & STROBE_MASK), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_illegal", int'(illegal_op), 0);
      mNext = 0;
      mCntNext = 0;
      route.delete();
      return;
    end
    e = expTab[mState];
    if (mState == 0 && bus.mem_ready) e = e | FETCH_DONE;
    chk("state", int'(state), mState);
    chk("ctrl", int'(dutCtrl), int'(e));
    chk("halted", int'(halted), int'(mState == 12));
    chk("illegal_op", int'(illegal_op), int'(mState == 1 && bus.opcode == 3'd6));
    chk("instr_retired", int'(instr_retired), mCnt);

    if (mState == 12) nx = 12;
    else if ((mState == 0 || mState == 3 || mState == 5) && !bus.mem_ready) nx = mState;
    else if (mState == 0) nx = 1;
    else begin
      if (mState == 1) begin
        route.delete();
        case (bus.opcode)
          3'd0: begin route.push_back(6); route.push_back(7); end
          3'd1: begin route.push_back(10); route.push_back(11); end
          3'd2, 3'd3: route.push_back(2);
          3'd4: route.push_back(8);
          3'd5: route.push_back(9);
          3'd7: route.push_back(12);
          default: ;
        endcase
      end else if (mState == 2) begin
        if (bus.opcode == 3'd3) route.push_back(5);
        else begin route.push_back(3); route.push_back(4); end
      end
      nx = (route.size() > 0) ? route.pop_front() : 0;
    end
    mNext = nx;
    mCntNext = mCnt;
    if ((nx == 0 && mState != 0 && mState != 1) || (nx == 12 && mState != 12))
      mCntNext = (mCnt + 1) % (1 << CW);
  endtask

  // driver
  task automatic step(input logic r, input logic [2:0] op, input logic rdy);
    @(posedge clk);
    #1;
    mState = mNext;
    mCnt = mCntNext;
    rst = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    @(negedge clk);
    check_cycle();
  endtask

  function automatic logic [2:0] pick_op();
    int v;
    v = $urandom_range(0, 19);
    return (v < 18) ? 3'(v % 7) : 3'd7;
  endfunction

  initial begin
    int n3, nHalt;
    logic r, rdy;
    logic [2:0] op;

    rst = 1'b1;
    bus.opcode = 3'd0;
    bus.mem_ready = 1'b0;
    expTab[0]  = ctrl(0,0,0,0,1,0,0,0,0,0,0,1,0);
    expTab[1]  = ctrl(0,0,0,0,0,0,0,0,0,0,0,2,0);
    expTab[2]  = ctrl(0,0,0,0,0,0,0,0,0,0,1,2,0);
    expTab[3]  = ctrl(0,0,0,1,1,0,0,0,0,0,0,0,0);
    expTab[4]  = ctrl(0,0,0,0,0,0,0,0,1,1,0,0,0);
    expTab[5]  = ctrl(0,0,0,1,0,1,0,0,0,0,0,0,0);
    expTab[6]  = ctrl(0,0,0,0,0,0,0,0,0,0,1,0,2);
    expTab[7]  = ctrl(0,0,0,0,0,0,0,1,0,1,0,0,0);
    expTab[8]  = ctrl(0,1,1,0,0,0,0,0,0,0,1,0,1);
    expTab[9]  = ctrl(1,0,2,0,0,0,0,0,0,0,0,0,0);
    expTab[10] = ctrl(0,0,0,0,0,0,0,0,0,0,1,2,0);
    expTab[11] = ctrl(0,0,0,0,0,0,0,0,0,1,0,0,0);
    expTab[12] = 16'h0000;

    // Reset, then R-type: states 0,1,6,7,0
    step(1, 3'd0, 1); step(1, 3'd0, 1);
    step(0, 3'd0, 1);
    chk("pin_reset_state", int'(state), 0);
    chk("pin_reset_memread", int'(bus.mem_read), 1);
    chk("pin_reset_cnt", int'(instr_retired), 0);
    step(0, 3'd0, 1); chk("pin_r_decode", int'(state), 1);
    step(0, 3'd0, 1); chk("pin_r_ex", int'(state), 6);
    chk("pin_r_ex_regwrite", int'(bus.reg_write), 0);
    step(0, 3'd0, 1); chk("pin_r_wb", int'(state), 7);
    chk("pin_r_wb_regwrite", int'(bus.reg_write), 1);
    chk("pin_r_wb_regdst", int'(bus.reg_dst), 1);
    step(0, 3'd0, 1); chk("pin_r_back_fetch", int'(state), 0);
    chk("pin_r_cnt", int'(instr_retired), 1);

    // LW with mem_ready low three cycles in MEM_RD
    n3 = 0;
    step(0, 3'd2, 1); step(0, 3'd2, 1);
    repeat (3) begin
      step(0, 3'd2, 0);
      if (state == 4'd3 && bus.mem_read && bus.i_or_d) n3++;
    end
    step(0, 3'd2, 1);
    if (state == 4'd3 && bus.mem_read && bus.i_or_d) n3++;
    chk("pin_lw_wait_cycles", n3, 4);
    step(0, 3'd2, 1); chk("pin_lw_wb", int'(state), 4);
    chk("pin_lw_memtoreg", int'(bus.mem_to_reg), 1);
    step(0, 3'd4, 1); chk("pin_lw_cnt", int'(instr_retired), 2);

    // BEQ then J
    step(0, 3'd4, 1);
    step(0, 3'd4, 1); chk("pin_beq_state", int'(state), 8);
    chk("pin_beq_pwc", int'(bus.pc_write_cond), 1);
    chk("pin_beq_aluop", int'(bus.alu_op), 1);
    step(0, 3'd5, 1); step(0, 3'd5, 1);
    step(0, 3'd5, 1); chk("pin_j_state", int'(state), 9);
    chk("pin_j_pw", int'(bus.pc_write), 1);
    chk("pin_j_pcsrc", int'(bus.pc_source), 2);
    step(0, 3'd6, 1); chk("pin_bj_cnt", int'(instr_retired), 4);

    // Illegal opcode then HALT
    step(0, 3'd6, 1); chk("pin_illegal_pulse", int'(illegal_op), 1);
    step(0, 3'd7, 1); chk("pin_illegal_fetch", int'(state), 0);
    chk("pin_illegal_low", int'(illegal_op), 0);
    chk("pin_illegal_cnt", int'(instr_retired), 4);
    step(0, 3'd7, 1);
    step(0, 3'd7, 1); chk("pin_halt_state", int'(state), 12);
    chk("pin_halt_cnt", int'(instr_retired), 5);
    nHalt = 0;
    repeat (20) begin
      step(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (halted && (dutCtrl & STROBE_MASK) == 16'h0) nHalt++;
    end
    chk("pin_halt_sticky", nHalt, 20);

    // Reset while waiting in MEM_WR
    step(1, 3'd0, 0);
    chk("pin_rst_halted", int'(halted), 0);
    step(0, 3'd1, 1); step(0, 3'd1, 1); step(0, 3'd1, 1); step(0, 3'd1, 1);
    step(0, 3'd3, 1); step(0, 3'd3, 1); step(0, 3'd3, 1);
    step(0, 3'd3, 0); chk("pin_sw_memwrite", int'(bus.mem_write), 1);
    step(1, 3'd3, 0); chk("pin_rst_memwrite", int'(bus.mem_write), 0);
    step(0, 3'd1, 0); chk("pin_rst_state", int'(state), 0);
    chk("pin_rst_cnt", int'(instr_retired), 0);
    chk("pin_rst_halted_after", int'(halted), 0);

    // 16 ADDI: counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(0, 3'd1, 1);
      chk("pin_wrap_cnt", int'(instr_retired), i);
      repeat (3) step(0, 3'd1, 1);
    end
    step(0, 3'd1, 1); chk("pin_wrap_zero", int'(instr_retired), 0);

    // Randomized run against the model
    step(1, 3'd0, 1);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 99) == 0) || (mNext == 12 && $urandom_range(0, 4) == 0);
      if (mNext == 1) curOp = pick_op();
      op = (mNext == 1 || mNext == 2) ? curOp : 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      step(r, op, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
